div_unit: RTL

Multi-cycle RV32M divider in the execute stage, and the requesting end of the pipeline hold protocol. While a division is in progress it drives the hold request that the pipeline controller turns into its pipeline-wide hold. It honours the controller's flush by abandoning the operation. It computes DIV/DIVU/REM/REMU with a radix-2 restoring algorithm, one quotient bit per cycle.

---
 rtl/div_unit.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU), radix-2 restoring, one quotient bit per cycle.
// Drives the pipeline hold request while busy and abandons the operation on flush.
module div_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            div_start_i,
    input  logic [1:0]      div_op_i,
    input  logic [XLEN-1:0] div_dividend_i,
    input  logic [XLEN-1:0] div_divisor_i,
    input  logic [4:0]      div_rd_addr_i,
    input  logic            div_flush_i,
    output logic            div_hold_req_o,
    output logic            div_busy_o,
    output logic            div_valid_o,
    output logic [XLEN-1:0] div_result_o,
    output logic [4:0]      div_rd_addr_o
);

    localparam int unsigned CW = $clog2(XLEN);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [1:0]      op_q, op_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] divisor_q, divisor_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;

    logic            accept;
    logic            a_neg, b_neg, ovf;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] rem_step, quo_step;

    assign accept = div_start_i & ~div_flush_i;
    assign a_neg  = ~div_op_i[0] & div_dividend_i[XLEN-1];
    assign b_neg  = ~div_op_i[0] & div_divisor_i[XLEN-1];
    assign a_mag  = a_neg ? -div_dividend_i : div_dividend_i;
    assign b_mag  = b_neg ? -div_divisor_i : div_divisor_i;
    assign ovf    = ~div_op_i[0] && (div_dividend_i == {1'b1, {(XLEN-1){1'b0}}})
                    && (div_divisor_i == {XLEN{1'b1}});

    // Partial remainder stays below the divisor, so XLEN+1 bits hold the trial and its sign.
    assign trial    = {rem_q, quo_q[XLEN-1]} - {1'b0, divisor_q};
    assign rem_step = trial[XLEN] ? {rem_q[XLEN-2:0], quo_q[XLEN-1]} : trial[XLEN-1:0];
    assign quo_step = {quo_q[XLEN-2:0], ~trial[XLEN]};

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        op_d      = op_q;
        rd_d      = rd_q;
        divisor_d = divisor_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    op_d   = div_op_i;
                    rd_d   = div_rd_addr_i;
                    qneg_d = a_neg ^ b_neg;
                    rneg_d = a_neg;
                    if (div_divisor_i == '0) begin
                        quo_d   = '1;
                        rem_d   = div_dividend_i;
                        qneg_d  = 1'b0;
                        rneg_d  = 1'b0;
                        state_d = StDone;
                    end else if (ovf) begin
                        quo_d   = div_dividend_i;
                        rem_d   = '0;
                        qneg_d  = 1'b0;
                        rneg_d  = 1'b0;
                        state_d = StDone;
                    end else begin
                        divisor_d = b_mag;
                        quo_d     = a_mag;
                        rem_d     = '0;
                        count_d   = CW'(XLEN - 1);
                        state_d   = StCalc;
                    end
                end
            end
            StCalc: begin
                if (div_flush_i) begin
                    state_d = StIdle;
                end else begin
                    rem_d   = rem_step;
                    quo_d   = quo_step;
                    count_d = count_q - CW'(1);
                    if (count_q == '0) begin
                        quo_d   = qneg_q ? -quo_step : quo_step;
                        rem_d   = rneg_q ? -rem_step : rem_step;
                        count_d = '0;
                        state_d = StDone;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            count_q   <= '0;
            op_q      <= '0;
            rd_q      <= '0;
            divisor_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            divisor_q <= divisor_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
        end
    end

    assign div_hold_req_o = ((state_q == StIdle) & accept) | (state_q == StCalc);
    assign div_busy_o     = (state_q != StIdle);
    assign div_valid_o    = (state_q == StDone) & ~div_flush_i;
    assign div_result_o   = op_q[1] ? rem_q : quo_q;
    assign div_rd_addr_o  = rd_q;

endmodule
